key_event_decoder: RTL and testbench
====================================

// Module: key_event_decoder
// PURPOSE
//  Consumes the debounced, active-low key level produced by the key debounce filter.
//  Classifies each key gesture as short press, double click or long press.
//  Emits one-cycle event pulses and maintains a wrap-around selection index
//  (picture/mode select for the VGA display path).
//  Sits between the debounce filter and the display control logic; same clock domain.
// PARAMETERS
//  LONG_CYC   50_000_000  held-low cycles that qualify a long press (1 s @ 50 MHz)
//  DBL_CYC    15_000_000  max release-to-second-press gap for a double click (300 ms)
//  REPEAT_CYC 10_000_000  auto-repeat period after a long press (AUTO_REPEAT_EN only)
//  SEL_NUM    4           number of selection values; sel runs 0..SEL_NUM-1
//  SEL_W      2           width of sel; must satisfy 2**SEL_W >= SEL_NUM
// PORTS
//  clk          in   1      system clock, 50 MHz
//  rst_n        in   1      asynchronous reset, active low
//  key_in       in   1      debounced key level: 0 = pressed, 1 = released; synchronous to clk
//  short_pulse  out  1      one-cycle pulse: single short press confirmed
//  double_pulse out  1      one-cycle pulse: double click confirmed
//  long_pulse   out  1      one-cycle pulse: long press threshold reached
//  repeat_pulse out  1      one-cycle pulse: auto-repeat tick while still held
//  sel          out  SEL_W  selection index
// BEHAVIOUR
//  - Reset: all pulse outputs 0, sel 0, state IDLE, counters 0, key_in history register 1.
//  - Edges: key_r <= key_in. press = key_r & ~key_in. release = ~key_r & key_in.
//  - One 26-bit cycle counter cnt; every *_CYC parameter must be in 1 .. 2**26-1.
//  - IDLE:   cnt=0. On press -> PRESS1.
//  - PRESS1: cnt++ each cycle while held.
//            - If cnt==LONG_CYC-1 while still low: long_pulse, cnt=0 -> LONG.
//            - On release before that: cnt=0 -> WAIT2.
//  - LONG:   on release -> IDLE. No short or double event is ever generated for this gesture.
//  - WAIT2:  cnt++ each cycle.
//            - On press -> PRESS2.
//            - Else if cnt==DBL_CYC-1: short_pulse -> IDLE.
//            - If press and timeout occur in the same cycle, press wins (double click).
//  - PRESS2: on release: double_pulse -> IDLE. There is no long detection in PRESS2.
//  - Unused/illegal state encodings -> IDLE.
//  - All outputs are registered. Each pulse is exactly 1 clk wide. At most one pulse is high per cycle.
//  - sel updates on the same clock edge that raises the corresponding pulse:
//      short:  sel+1, wraps SEL_NUM-1 -> 0
//      double: sel-1, wraps 0 -> SEL_NUM-1
//      long:   sel = 0
//      repeat: sel+1 with wrap
//  - key_in is not re-debounced; glitches are the upstream filter's responsibility.
//  - rst_n asserted mid-gesture: immediate return to reset values; no pulse emitted on or after reset release.
//    A key already held low at reset release is not a press; a fresh 1->0 edge is required.
// CONFIGURATION
//  - AUTO_REPEAT_EN defined:
//      In LONG, a second counter rcnt (reset to 0 on LONG entry) counts while the key is held.
//      At rcnt==REPEAT_CYC-1: repeat_pulse, rcnt=0, repeat indefinitely until release.
//      Release stops the repeats with no extra pulse.
//  - AUTO_REPEAT_EN undefined:
//      repeat_pulse tied 0 and rcnt not instantiated.
//      REPEAT_CYC is ignored.
// TESTING  (bench params: LONG_CYC=20, DBL_CYC=10, REPEAT_CYC=5, SEL_NUM=3, SEL_W=2)
//  1. Hold low 5 cycles, release, stay high 20 cycles -> exactly one short_pulse, 10 cycles after release edge; sel 0->1; no other pulses.
//  2. Three isolated short presses -> sel 1,2,0 (wrap); 3 short_pulses, 0 double.
//  3. Low 4, high 3, low 4, high -> one double_pulse on second release; sel 0->2; no short_pulse.
//  4. Hold low 30 cycles -> long_pulse on 20th held cycle, sel->0; release gives no short/double.
//  5. AUTO_REPEAT_EN: hold low 37 cycles -> long at 20, repeat_pulse at 25,30,35; sel 0->0->1->2->0.
//     Without the macro, the same stimulus gives repeat_pulse constant 0 and sel stays 0.
//  6. Assert rst_n low in WAIT2 (3 cycles after a release) -> all outputs 0, sel 0, no pulse after reset release.
//     Key held low across reset release -> no event until a new press edge.

Source files
------------

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Turns the debounced, active-low key level into short / double / long
//   gesture events (one-cycle pulses) and keeps a wrap-around selection index.
//   Optional feature: define AUTO_REPEAT_EN to emit repeat_pulse ticks every
//   REPEAT_CYC cycles while a long press is still held.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | key released, waiting for a fresh press edge
// PRESS1 | first press held, timing toward the long-press threshold
// LONG   | long press reported, waiting for release (auto-repeat here)
// WAIT2  | first press released, waiting for a second press or timeout
// PRESS2 | second press held, double click reported on its release
module key_event_decoder #(
   parameter int LONG_CYC   = 50_000_000,
   parameter int DBL_CYC    = 15_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int SEL_NUM    = 4,
   parameter int SEL_W      = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_in,
   output logic             short_pulse,
   output logic             double_pulse,
   output logic             long_pulse,
   output logic             repeat_pulse,
   output logic [SEL_W-1:0] sel
);

   localparam int CNT_W = 26;
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYC - 1);
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(SEL_NUM - 1);

   // Elaboration-time range checks on the configuration.
   if (LONG_CYC < 1 || LONG_CYC > 2**CNT_W - 1) begin : g_chk_long
      $error("key_event_decoder: LONG_CYC out of range");
   end
   if (DBL_CYC < 1 || DBL_CYC > 2**CNT_W - 1) begin : g_chk_dbl
      $error("key_event_decoder: DBL_CYC out of range");
   end
   if (REPEAT_CYC < 1 || REPEAT_CYC > 2**CNT_W - 1) begin : g_chk_rep
      $error("key_event_decoder: REPEAT_CYC out of range");
   end
   if (SEL_NUM < 1 || 2**SEL_W < SEL_NUM) begin : g_chk_sel
      $error("key_event_decoder: SEL_W too narrow for SEL_NUM");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      LONG   = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               key_r_q, key_r_d;
   logic               arm_q, arm_d;
   logic               short_q, short_d;
   logic               double_q, double_d;
   logic               long_q, long_d;
   logic               repeat_q, repeat_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               press_ev, rel_ev;

   // arm_q blocks a key that is already held low when reset lifts: a press
   // only counts once the key has been seen released at least once.
   assign press_ev = key_r_q & ~key_in & arm_q;
   assign rel_ev   = ~key_r_q & key_in;
   assign key_r_d  = key_in;
   assign arm_d    = arm_q | key_in;

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYC - 1);
   logic [CNT_W-1:0] rcnt_q, rcnt_d;

   // Repeat timer: runs only while a long press is held, cleared elsewhere.
   always_comb begin
      rcnt_d = '0;
      if (state_q == LONG && !key_in) begin
         rcnt_d = (rcnt_q == REP_TC) ? '0 : rcnt_q + CNT_W'(1);
      end
   end

   // Repeat timer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rcnt_q <= '0;
      else        rcnt_q <= rcnt_d;
   end
`endif

   // State, gesture timer and key history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         key_r_q <= 1'b1;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_r_q <= key_r_d;
         arm_q   <= arm_d;
      end
   end

   // Next-state and gesture timer logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (press_ev) state_d = PRESS1;
         end
         PRESS1: begin
            if (rel_ev) begin
               cnt_d   = '0;
               state_d = WAIT2;
            end else if (cnt_q == LONG_TC) begin
               cnt_d   = '0;
               state_d = LONG;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LONG: begin
            cnt_d = '0;
            if (rel_ev) state_d = IDLE;
         end
         WAIT2: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (press_ev) begin
               cnt_d   = '0;
               state_d = PRESS2;
            end else if (cnt_q == DBL_TC) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         PRESS2: begin
            cnt_d = '0;
            if (rel_ev) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Event pulses and selection index update, both registered next edge.
   always_comb begin
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
         PRESS1: long_d   = ~rel_ev & (cnt_q == LONG_TC);
         WAIT2:  short_d  = ~press_ev & (cnt_q == DBL_TC);
         PRESS2: double_d = rel_ev;
`ifdef AUTO_REPEAT_EN
         LONG:   repeat_d = ~key_in & (rcnt_q == REP_TC);
`endif
         default: ;
      endcase

      sel_d = sel_q;
      if (short_d || repeat_d) begin
         sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
      end else if (double_d) begin
         sel_d = (sel_q == '0) ? SEL_MAX : sel_q - SEL_W'(1);
      end else if (long_d) begin
         sel_d = '0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         sel_q    <= '0;
      end else begin
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
         sel_q    <= sel_d;
      end
   end

   assign short_pulse  = short_q;
   assign double_pulse = double_q;
   assign long_pulse   = long_q;
   assign repeat_pulse = repeat_q;
   assign sel          = sel_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder. Each segment is a key level
// sequence applied right after a reset; a gesture-level reference model
// scans the whole sequence (press/release indices, run lengths) and derives
// the expected pulse per cycle and the running selection index.
module tb_key_event_decoder;

   localparam int LONG_CYC   = 20;
   localparam int DBL_CYC    = 10;
   localparam int REPEAT_CYC = 5;
   localparam int SEL_NUM    = 3;
   localparam int SEL_W      = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             key_in = 1'b1;
   logic             short_pulse, double_pulse, long_pulse, repeat_pulse;
   logic [SEL_W-1:0] sel;

   int n_cmp = 0;
   int n_bad = 0;

   int seq[$];
   int e_sh[$], e_db[$], e_lg[$], e_rp[$], e_sel[$];

   always #5 clk = ~clk;

   key_event_decoder #(
      .LONG_CYC(LONG_CYC), .DBL_CYC(DBL_CYC), .REPEAT_CYC(REPEAT_CYC),
      .SEL_NUM(SEL_NUM), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in),
      .short_pulse(short_pulse), .double_pulse(double_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .sel(sel)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic add(input int v, input int len);
      for (int k = 0; k < len; k++) seq.push_back(v);
   endtask

   // Gesture-level reference: walk the sequence gesture by gesture.
   function automatic void build_expected();
      int n, i, p, r, q, r2, s;
      bit found;
      n = seq.size();
      e_sh = {}; e_db = {}; e_lg = {}; e_rp = {}; e_sel = {};
      for (int k = 0; k < n; k++) begin
         e_sh.push_back(0); e_db.push_back(0); e_lg.push_back(0);
         e_rp.push_back(0); e_sel.push_back(0);
      end
      i = 0;
      while (i < n && seq[i] == 0) i++;          // held low from reset: ignored
      while (i < n) begin
         while (i < n && seq[i] == 1) i++;
         if (i >= n) break;
         p = i;
         r = p;
         while (r < n && seq[r] == 0) r++;
         if (r - p > LONG_CYC) begin
            e_lg[p + LONG_CYC] = 1;
`ifdef AUTO_REPEAT_EN
            for (int k = p + LONG_CYC + REPEAT_CYC; k < r; k += REPEAT_CYC) e_rp[k] = 1;
`endif
            i = r;
            continue;
         end
         if (r >= n) break;
         found = 0;
         q = 0;
         for (int g = 1; g <= DBL_CYC && r + g < n; g++) begin
            if (!found && seq[r + g] == 0) begin
               found = 1;
               q = r + g;
            end
         end
         if (found) begin
            r2 = q;
            while (r2 < n && seq[r2] == 0) r2++;
            if (r2 >= n) break;
            e_db[r2] = 1;
            i = r2;
         end else begin
            if (r + DBL_CYC >= n) break;
            e_sh[r + DBL_CYC] = 1;
            i = r + DBL_CYC + 1;
         end
      end
      s = 0;
      for (int k = 0; k < n; k++) begin
         if (e_sh[k] != 0 || e_rp[k] != 0) s = (s + 1) % SEL_NUM;
         else if (e_db[k] != 0)            s = (s + SEL_NUM - 1) % SEL_NUM;
         else if (e_lg[k] != 0)            s = 0;
         e_sel[k] = s;
      end
   endfunction

   task automatic check_reset_vals(input string name);
      check($sformatf("%s rst short", name), 32'(short_pulse), 0);
      check($sformatf("%s rst double", name), 32'(double_pulse), 0);
      check($sformatf("%s rst long", name), 32'(long_pulse), 0);
      check($sformatf("%s rst repeat", name), 32'(repeat_pulse), 0);
      check($sformatf("%s rst sel", name), 32'(sel), 0);
   endtask

   // Reset (asynchronously, mid-whatever), then play seq and compare each cycle.
   task automatic run_segment(input string name);
      @(negedge clk);
      rst_n  = 1'b0;
      key_in = (seq[0] != 0);
      #1;
      check_reset_vals(name);
      @(negedge clk);
      @(negedge clk);
      check_reset_vals(name);
      build_expected();
      rst_n = 1'b1;
      for (int i = 0; i < seq.size(); i++) begin
         key_in = (seq[i] != 0);
         @(negedge clk);
         check($sformatf("%s[%0d] short", name, i), 32'(short_pulse), e_sh[i]);
         check($sformatf("%s[%0d] double", name, i), 32'(double_pulse), e_db[i]);
         check($sformatf("%s[%0d] long", name, i), 32'(long_pulse), e_lg[i]);
         check($sformatf("%s[%0d] repeat", name, i), 32'(repeat_pulse), e_rp[i]);
         check($sformatf("%s[%0d] sel", name, i), 32'(sel), e_sel[i]);
      end
   endtask

   initial begin
      // Directed gestures, including timing boundaries.
      seq = {};
      add(1, 3);
      add(0, 5);  add(1, 20);                          // short
      for (int k = 0; k < 3; k++) begin add(0, 3); add(1, 14); end
      add(0, 4);  add(1, 3);  add(0, 4);  add(1, 15);  // double
      add(0, 2);  add(1, 10); add(0, 2);  add(1, 15);  // second press on timeout cycle
      add(0, 2);  add(1, 11); add(0, 2);  add(1, 15);  // one cycle too late: two shorts
      add(0, 20); add(1, 15);                          // one short of long: short
      add(0, 21); add(1, 15);                          // exactly long
      add(0, 30); add(1, 15);                          // long, then release
      add(0, 37); add(1, 15);                          // long with repeats
      run_segment("dir");

      // Randomized gestures, some segments starting with the key held low.
      for (int s = 0; s < 6; s++) begin
         seq = {};
         add(0, $urandom_range(0, 2));
         add(1, $urandom_range(1, 3));
         while (seq.size() < 250) begin
            add(0, $urandom_range(1, 40));
            add(1, $urandom_range(1, 14));
         end
         run_segment($sformatf("rnd%0d", s));
      end

      // Reset during WAIT2, three cycles after a release (after a short, sel=1).
      seq = {};
      add(1, 2); add(0, 3); add(1, 12); add(0, 4); add(1, 3);
      run_segment("w2a");
      // Key held low across reset release, then a fresh press gives one short.
      seq = {};
      add(0, 8); add(1, 3); add(0, 4); add(1, 15);
      run_segment("w2b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
